// File: rtl/snitch_icache_pkg.sv
// Shared types for the Snitch instruction cache.
// Contents: config_t (cache geometry), refill_state_e (refill responder FSM)
// and the fallback geometry used when a config_t field is left at zero.
package snitch_icache_pkg;

  typedef struct packed {
    int unsigned FETCH_AW;
    int unsigned LINE_WIDTH;
    int unsigned PENDING_IW;
  } config_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESPOND
  } refill_state_e;

  // A zero field in config_t selects these values, so a default-constructed
  // CFG still describes a usable cache.
  localparam int unsigned DFLT_FETCH_AW   = 32;
  localparam int unsigned DFLT_LINE_WIDTH = 128;
  localparam int unsigned DFLT_PENDING_IW = 2;

  function automatic int unsigned cfg_or_default(input int unsigned v, input int unsigned d);
    return (v == 0) ? d : v;
  endfunction

endpackage

// File: rtl/snitch_icache_refill_responder.sv
// Refill responder: turns one cache-line refill request into BEATS memory
// beat reads, assembles the returned beats into a line and answers with it.
// Ports: in_req_* (line request, valid/ready), in_rsp_* (line response,
// valid/ready), mem_* (beat requests with grant, in-order unstallable rvalid).
// Optional: SNITCH_ICACHE_REFILL_CRITICAL_WORD_FIRST_EN fetches the requested
// beat first and wraps around the line.
module snitch_icache_refill_responder
  import snitch_icache_pkg::*;
#(
  parameter config_t       CFG    = '0,
  parameter int unsigned   MEM_DW = 64,
  localparam int unsigned  AW     = cfg_or_default(CFG.FETCH_AW, DFLT_FETCH_AW),
  localparam int unsigned  LW     = cfg_or_default(CFG.LINE_WIDTH, DFLT_LINE_WIDTH),
  localparam int unsigned  IW     = cfg_or_default(CFG.PENDING_IW, DFLT_PENDING_IW)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW-1:0] in_req_addr_i,
  input  logic [IW-1:0] in_req_id_i,
  input  logic          in_req_valid_i,
  output logic          in_req_ready_o,
  output logic [LW-1:0] in_rsp_data_o,
  output logic          in_rsp_error_o,
  output logic [IW-1:0] in_rsp_id_o,
  output logic          in_rsp_valid_o,
  input  logic          in_rsp_ready_i,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [MEM_DW-1:0] mem_rdata_i,
  input  logic          mem_err_i
);

  localparam int unsigned BEATS      = LW / MEM_DW;
  localparam int unsigned BIW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CW         = $clog2(BEATS + 1);
  localparam int unsigned LINE_BYTES = LW / 8;
  localparam int unsigned BEAT_OFF   = $clog2(MEM_DW / 8);

  refill_state_e state_q, state_d;

  logic [AW-1:0]  base_q;
  logic [IW-1:0]  id_q;
  logic           err_q;
  logic [CW-1:0]  issue_q;
  logic [CW-1:0]  recv_q;
  logic [BIW-1:0] start_q;
  logic [BIW-1:0] start_d;
  logic [BEATS-1:0][MEM_DW-1:0] line_q;

  logic           accept;
  logic           issuing;
  logic           gnt_fire;
  logic           rsp_fire;
  logic [BIW-1:0] issue_idx;
  logic [BIW-1:0] recv_idx;

  // (s + k) mod BEATS without a divider; both operands are below BEATS.
  function automatic logic [BIW-1:0] wrap_idx(input logic [BIW-1:0] s, input logic [CW-1:0] k);
    logic [CW:0] sum;
    sum = (CW+1)'(s) + (CW+1)'(k);
    if (sum >= (CW+1)'(BEATS)) sum = sum - (CW+1)'(BEATS);
    return BIW'(sum);
  endfunction

`ifdef SNITCH_ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
  assign start_d = BIW'((in_req_addr_i & AW'(LINE_BYTES - 1)) >> BEAT_OFF);
`else
  assign start_d = '0;
`endif

  assign accept    = (state_q == IDLE) && in_req_valid_i;
  assign issuing   = (state_q == FETCH) && (issue_q < CW'(BEATS));
  assign gnt_fire  = issuing && mem_gnt_i;
  // Beats beyond what was granted are stray and dropped.
  assign rsp_fire  = mem_rvalid_i && (recv_q < issue_q);
  assign issue_idx = wrap_idx(start_q, issue_q);
  assign recv_idx  = wrap_idx(start_q, recv_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    in_req_ready_o = 1'b0;
    in_rsp_valid_o = 1'b0;
    in_rsp_data_o  = '0;
    in_rsp_error_o = 1'b0;
    in_rsp_id_o    = '0;
    mem_req_o      = 1'b0;
    mem_addr_o     = '0;
    unique case (state_q)
      IDLE: begin
        in_req_ready_o = 1'b1;
        if (in_req_valid_i) state_d = FETCH;
      end
      FETCH: begin
        mem_req_o = issuing;
        if (issuing) mem_addr_o = base_q + (AW'(issue_idx) << BEAT_OFF);
        // Leave as soon as the final beat lands so the response is
        // presented on the very next cycle.
        if (rsp_fire && (recv_q == CW'(BEATS - 1))) state_d = RESPOND;
      end
      RESPOND: begin
        in_rsp_valid_o = 1'b1;
        in_rsp_data_o  = line_q;
        in_rsp_error_o = err_q;
        in_rsp_id_o    = id_q;
        if (in_rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      issue_q <= '0;
      recv_q  <= '0;
      start_q <= '0;
      line_q  <= '0;
    end else if (accept) begin
      base_q  <= in_req_addr_i & ~AW'(LINE_BYTES - 1);
      id_q    <= in_req_id_i;
      err_q   <= 1'b0;
      issue_q <= '0;
      recv_q  <= '0;
      start_q <= start_d;
    end else begin
      // Grant and response are independent; both may fire in one cycle.
      if (gnt_fire) issue_q <= issue_q + CW'(1);
      if (rsp_fire) begin
        line_q[recv_idx] <= mem_rdata_i;
        recv_q           <= recv_q + CW'(1);
        err_q            <= err_q | mem_err_i;
      end
    end
  end

`ifndef SYNTHESIS
  stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> (recv_q < issue_q));
`endif

endmodule

// File: tb/tb_snitch_icache_refill_responder.sv
// Bench for snitch_icache_refill_responder: 128-bit lines, 32-bit beats.
// A transaction-level model predicts grant addresses and the assembled line;
// directed cases pin the model with literal values, then a stall-heavy run.
module tb_snitch_icache_refill_responder;

  localparam int unsigned AW = 32, LW = 128, IW = 4, DW = 32, BEATS = 4;
  localparam snitch_icache_pkg::config_t CFG = '{FETCH_AW: AW, LINE_WIDTH: LW, PENDING_IW: IW};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] in_req_addr = '0;
  logic [IW-1:0] in_req_id = '0;
  logic          in_req_valid = 1'b0;
  logic          in_req_ready_o;
  logic [LW-1:0] in_rsp_data_o;
  logic          in_rsp_error_o;
  logic [IW-1:0] in_rsp_id_o;
  logic          in_rsp_valid_o;
  logic          in_rsp_ready = 1'b1;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_err = 1'b0;

  always #5 clk = ~clk;

  snitch_icache_refill_responder #(.CFG(CFG), .MEM_DW(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_req_addr_i(in_req_addr), .in_req_id_i(in_req_id),
    .in_req_valid_i(in_req_valid), .in_req_ready_o(in_req_ready_o),
    .in_rsp_data_o(in_rsp_data_o), .in_rsp_error_o(in_rsp_error_o),
    .in_rsp_id_o(in_rsp_id_o), .in_rsp_valid_o(in_rsp_valid_o),
    .in_rsp_ready_i(in_rsp_ready),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hCAFE, a[15:0]};
  endfunction

  // ---- transaction model (updated at posedge) ----
  bit            busy = 1'b0;
  int            grants = 0, recvs = 0;
  logic [31:0]   t_addr [BEATS];
  logic [127:0]  t_line = '0;
  logic [3:0]    t_id = '0;
  logic          t_err = 1'b0;
  logic [31:0]   err_addr = 32'hFFFF_FFFF;
  int            cyc = 0, acc_cyc = 0, lat = 0;
  int            n_acc = 0, n_ret = 0;
  logic [127:0]  last_data = '0;
  logic          last_err = 1'b0;
  logic [3:0]    last_id = '0;
  logic [31:0]   gnt_log [$];

  // ---- memory / response-side knobs (set by stimulus) ----
  int            gnt_pct = 100, rv_pct = 100, rdy_mode = 0;
  logic [31:0]   pend [$];

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      busy = 1'b0; grants = 0; recvs = 0;
    end else if (busy && recvs == BEATS) begin
      if (in_rsp_ready) begin
        busy = 1'b0; n_ret++;
        last_data = in_rsp_data_o; last_err = in_rsp_error_o; last_id = in_rsp_id_o;
      end
    end else if (busy) begin
      if (mem_gnt) begin grants++; gnt_log.push_back(mem_addr_o); end
      if (mem_rvalid) begin
        recvs++;
        if (recvs == BEATS) lat = cyc - acc_cyc + 1;
      end
    end else if (in_req_valid) begin
      logic [31:0] base;
      int st;
      busy = 1'b1; grants = 0; recvs = 0; acc_cyc = cyc; n_acc++;
      base = in_req_addr & ~32'hF;
`ifdef SNITCH_ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
      st = int'(in_req_addr[3:2]);
`else
      st = 0;
`endif
      t_err = 1'b0;
      for (int k = 0; k < BEATS; k++) begin
        t_addr[k] = base + 32'(((st + k) % BEATS) * 4);
        t_line[k*32 +: 32] = mem_word(base + 32'(k * 4));
        if (base + 32'(k * 4) == err_addr) t_err = 1'b1;
      end
      t_id = in_req_id;
    end
  end

  // Compare DUT against model, then drive memory and response-ready.
  always @(negedge clk) begin
    logic [31:0] a;
    if (rst_n) begin
      chk("req_ready", in_req_ready_o, !busy);
      chk("mem_req", mem_req_o, busy && grants < BEATS);
      if (busy && grants < BEATS) chk("mem_addr", mem_addr_o, t_addr[grants]);
      chk("rsp_valid", in_rsp_valid_o, busy && recvs == BEATS);
      if (busy && recvs == BEATS) begin
        chk("rsp_data", in_rsp_data_o, t_line);
        chk("rsp_id", in_rsp_id_o, t_id);
        chk("rsp_err", in_rsp_error_o, t_err);
      end
      if (!busy) begin
        chk("idle_data", in_rsp_data_o, 0);
        chk("idle_addr", {in_rsp_id_o, in_rsp_error_o, mem_addr_o}, 0);
      end
    end else begin
      pend.delete();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    if (rst_n && pend.size() > 0 && $urandom_range(99) < rv_pct) begin
      a = pend.pop_front();
      mem_rvalid = 1'b1; mem_rdata = mem_word(a); mem_err = (a == err_addr);
    end
    if (rst_n && busy && grants < BEATS && $urandom_range(99) < gnt_pct) begin
      mem_gnt = 1'b1;
      pend.push_back(t_addr[grants]);
    end
    in_rsp_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : ($urandom_range(99) < 60);
  end

  task automatic send(input logic [31:0] a, input logic [3:0] id);
    int n0 = n_acc;
    int k = 0;
    in_req_addr = a; in_req_id = id; in_req_valid = 1'b1;
    while (n_acc == n0 && k < 500) begin @(negedge clk); k++; end
    in_req_valid = 1'b0;
    if (n_acc == n0) chk("accept_timeout", n_acc - n0, 1);
  endtask

  task automatic wait_ret(input int target);
    int k = 0;
    while (n_ret < target && k < 2000) begin @(negedge clk); k++; end
    if (n_ret < target) chk("rsp_timeout", n_ret, target);
  endtask

  task automatic txn(input logic [31:0] a, input logic [3:0] id);
    int t = n_ret + 1;
    send(a, id);
    wait_ret(t);
  endtask

  logic [127:0] line_1000;
  logic [31:0]  seq_1008 [BEATS];
  int g0, a0, r0, k;

  initial begin
    line_1000 = 128'hCAFE100C_CAFE1008_CAFE1004_CAFE1000;
`ifdef SNITCH_ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    seq_1008 = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
`else
    seq_1008 = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
`endif
    repeat (3) @(negedge clk);
    chk("reset_req_ready", in_req_ready_o, 1);
    chk("reset_rsp_valid", in_rsp_valid_o, 0);
    chk("reset_mem_req", mem_req_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic refill: addresses, latency, data, id, error.
    g0 = gnt_log.size();
    txn(32'h1000, 4'd3);
    chk("t1_ngrants", gnt_log.size() - g0, 4);
    for (int i = 0; i < BEATS; i++) chk("t1_addr", gnt_log[g0 + i], 32'h1000 + 32'(4 * i));
    chk("t1_latency", lat, 6);
    chk("t1_data", last_data, line_1000);
    chk("t1_id", last_id, 3);
    chk("t1_err", last_err, 0);

    // Error on beat 2 does not abort the fetch.
    err_addr = 32'h1008;
    g0 = gnt_log.size();
    txn(32'h1000, 4'd5);
    chk("t2_ngrants", gnt_log.size() - g0, 4);
    chk("t2_err", last_err, 1);
    chk("t2_data", last_data, line_1000);
    err_addr = 32'hFFFF_FFFF;

    // Response held off for 10 cycles.
    rdy_mode = 1;
    send(32'h1040, 4'd7);
    k = 0;
    while (!(busy && recvs == BEATS) && k < 100) begin @(negedge clk); k++; end
    repeat (10) @(negedge clk);
    chk("t3_valid_held", in_rsp_valid_o, 1);
    chk("t3_req_ready", in_req_ready_o, 0);
    chk("t3_mem_req", mem_req_o, 0);
    chk("t3_id", in_rsp_id_o, 7);
    chk("t3_data", in_rsp_data_o, 128'hCAFE104C_CAFE1048_CAFE1044_CAFE1040);
    rdy_mode = 0;
    wait_ret(n_acc);

    // Unaligned address: order depends on critical-word-first build.
    g0 = gnt_log.size();
    txn(32'h1008, 4'd9);
    for (int i = 0; i < BEATS; i++) chk("t4_addr", gnt_log[g0 + i], seq_1008[i]);
    chk("t4_data", last_data, line_1000);
    chk("t4_id", last_id, 9);

    // Reset after two grants, then a clean fetch.
    send(32'h3000, 4'd2);
    k = 0;
    while (grants < 2 && k < 100) begin @(negedge clk); k++; end
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_ready", in_req_ready_o, 1);
    chk("t5_rst_mem_req", mem_req_o, 0);
    chk("t5_rst_valid", in_rsp_valid_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    g0 = gnt_log.size();
    txn(32'h2000, 4'd4);
    chk("t5_first_addr", gnt_log[g0], 32'h2000);
    chk("t5_data", last_data, 128'hCAFE200C_CAFE2008_CAFE2004_CAFE2000);
    chk("t5_id", last_id, 4);

    // Random stalls on grant, rvalid and response ready.
    gnt_pct = 70; rv_pct = 60; rdy_mode = 2;
    a0 = n_acc; r0 = n_ret;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(2)) @(negedge clk);
      txn($urandom & 32'h0000_FFFF, 4'(i));
    end
    chk("rand_accepted", n_acc - a0, 1000);
    chk("rand_returned", n_ret - r0, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
